// File: rtl/ghash_stream_engine_if.sv
// ---------------------------------------------------------------------------
// ghash_stream_engine_if
//   Bundles the control, block-stream and result signals of
//   ghash_stream_engine. clk and i_rst_n stay plain ports on the engine.
//
//   master : upstream side (CTR encryptor / sequencer). It drives start,
//            H, the two lengths and the block stream, and it observes
//            ready, busy, ghash and done.
//   slave  : the engine itself.
//
//   Signals
//     i_start      start pulse for a new hash (samples i_h and both sizes)
//     i_h          hash subkey H, GCM bit order (bit 0 = MSB)
//     i_aad_size   AAD length in bits
//     i_ct_size    ciphertext length in bits
//     i_blk_valid  block valid
//     o_blk_ready  engine accepts a block this cycle
//     i_blk        AAD blocks first, then ciphertext blocks
//     o_busy       hash in progress
//     o_ghash      final GHASH value
//     o_done       one-cycle pulse when o_ghash is valid
// ---------------------------------------------------------------------------
interface ghash_stream_engine_if #(
  parameter int LEN_W = 64
);
  logic             i_start;
  logic [127:0]     i_h;
  logic [LEN_W-1:0] i_aad_size;
  logic [LEN_W-1:0] i_ct_size;
  logic             i_blk_valid;
  logic             o_blk_ready;
  logic [127:0]     i_blk;
  logic             o_busy;
  logic [127:0]     o_ghash;
  logic             o_done;

  modport master (
    output i_start, i_h, i_aad_size, i_ct_size, i_blk_valid, i_blk,
    input  o_blk_ready, o_busy, o_ghash, o_done
  );

  modport slave (
    input  i_start, i_h, i_aad_size, i_ct_size, i_blk_valid, i_blk,
    output o_blk_ready, o_busy, o_ghash, o_done
  );
endinterface

// File: rtl/ghash_stream_engine.sv
// ---------------------------------------------------------------------------
// ghash_stream_engine
//   Streaming GHASH for the GCM datapath. It folds any number of AAD blocks,
//   then ciphertext blocks, then the length block into
//   X_i = (X_{i-1} xor B_i) * H over GF(2^128). A partial last block of
//   either segment has its bits beyond the segment length forced to zero.
//   The multiply is digit-serial: DIGIT_BITS bits of X per cycle,
//   MSB first, 128/DIGIT_BITS cycles per block.
//
//   Parameters
//     DIGIT_BITS  multiplier bits per cycle (1, 2, 4, 8, 16)
//     LEN_W       width of the bit-length inputs
//
//   Ports
//     clk          rising-edge clock
//     i_rst_n      synchronous active-low reset
//     bus          ghash_stream_engine_if.slave (start/H/sizes, block
//                  stream with valid/ready, busy, ghash, done)
//
//   Optional build macro GHASH_STREAM_PARTIAL_OUT_EN adds:
//     o_x_partial  X after every completed multiply
//     o_x_valid    one-cycle pulse when o_x_partial updates
// ---------------------------------------------------------------------------
module ghash_stream_engine #(
  parameter int DIGIT_BITS = 4,
  parameter int LEN_W      = 64
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  ghash_stream_engine_if.slave bus
`ifdef GHASH_STREAM_PARTIAL_OUT_EN
  ,
  output logic [127:0]         o_x_partial,
  output logic                 o_x_valid
`endif
);

  localparam int              MULT_CYCLES = 128 / DIGIT_BITS;
  localparam int              MCNT_W      = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam int              CNT_W       = LEN_W - 7;
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MULT_CYCLES - 1);
  // Reduction polynomial in GCM bit order: 11100001 || 0^120.
  localparam logic [127:0]    POLY_R      = {8'hE1, 120'd0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_AAD,
    S_CT,
    S_LEN,
    S_MULT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [127:0]     h_q, x_q, z_q, v_q, ghash_q;
  logic [LEN_W-1:0] aad_size_q, ct_size_q;
  // Block count = full-block counter + one flag for a trailing partial
  // block. Keeping them apart means ceil(size/128) never needs a carry
  // out of CNT_W bits, even at size = 2^LEN_W - 1.
  logic [CNT_W-1:0] aad_full_q, ct_full_q;
  logic             aad_part_q, ct_part_q;
  logic             len_done_q;
  logic [MCNT_W-1:0] mcnt_q;
  logic             done_q;

  logic             aad_left, ct_left, aad_last_part, ct_last_part;
  logic             blk_ready, accept, mult_last;
  logic [127:0]     blk_masked, z_step, v_step, len_blk;

  assign aad_left      = (aad_full_q != '0) || aad_part_q;
  assign ct_left       = (ct_full_q != '0) || ct_part_q;
  assign aad_last_part = (aad_full_q == '0) && aad_part_q;
  assign ct_last_part  = (ct_full_q == '0) && ct_part_q;
  assign accept        = bus.i_blk_valid && blk_ready;
  assign mult_last     = (state_q == S_MULT) && (mcnt_q == MCNT_LAST);
  assign len_blk       = {64'(aad_size_q), 64'(ct_size_q)};

  // Only the partial trailing block of a segment is masked; its valid bits
  // are the leftmost size[6:0] bits (GCM bit 0 = vector bit 127).
  always_comb begin
    blk_masked = bus.i_blk;
    if (state_q == S_AAD && aad_last_part)
      blk_masked = bus.i_blk & ~({128{1'b1}} >> aad_size_q[6:0]);
    else if (state_q == S_CT && ct_last_part)
      blk_masked = bus.i_blk & ~({128{1'b1}} >> ct_size_q[6:0]);
  end

  // One digit of the right-shift multiply: for each X bit (MSB first)
  // conditionally add V into Z, then V <- V * x mod P.
  // NOTE: blocking assignments here chain the DIGIT_BITS unrolled steps
  // within one cycle; state registers below use non-blocking <= only.
  always_comb begin
    z_step = z_q;
    v_step = v_q;
    for (int j = 0; j < DIGIT_BITS; j++) begin
      if (x_q[127-j]) z_step = z_step ^ v_step;
      v_step = v_step[0] ? ((v_step >> 1) ^ POLY_R) : (v_step >> 1);
    end
  end

  // NOTE: synchronous reset - i_rst_n only takes effect at a rising edge.
  always_ff @(posedge clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    blk_ready       = 1'b0;
    bus.o_blk_ready = 1'b0;
    bus.o_busy      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          if (bus.i_aad_size != '0)     state_d = S_AAD;
          else if (bus.i_ct_size != '0) state_d = S_CT;
          else                          state_d = S_LEN;
        end
      end
      S_AAD, S_CT: begin
        blk_ready  = 1'b1;
        bus.o_busy = 1'b1;
        if (accept) state_d = S_MULT;
      end
      S_LEN: begin
        bus.o_busy = 1'b1;
        state_d    = S_MULT;
      end
      S_MULT: begin
        bus.o_busy = 1'b1;
        if (mult_last) begin
          if (aad_left)         state_d = S_AAD;
          else if (ct_left)     state_d = S_CT;
          else if (!len_done_q) state_d = S_LEN;
          else                  state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    bus.o_blk_ready = blk_ready;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      h_q        <= '0;
      x_q        <= '0;
      z_q        <= '0;
      v_q        <= '0;
      ghash_q    <= '0;
      aad_size_q <= '0;
      ct_size_q  <= '0;
      aad_full_q <= '0;
      ct_full_q  <= '0;
      aad_part_q <= 1'b0;
      ct_part_q  <= 1'b0;
      len_done_q <= 1'b0;
      mcnt_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Every entry into MULT starts a fresh product Z = 0, V = H.
      if (state_q != S_MULT && state_d == S_MULT) begin
        z_q    <= '0;
        v_q    <= h_q;
        mcnt_q <= '0;
      end

      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            h_q        <= bus.i_h;
            aad_size_q <= bus.i_aad_size;
            ct_size_q  <= bus.i_ct_size;
            aad_full_q <= bus.i_aad_size[LEN_W-1:7];
            aad_part_q <= |bus.i_aad_size[6:0];
            ct_full_q  <= bus.i_ct_size[LEN_W-1:7];
            ct_part_q  <= |bus.i_ct_size[6:0];
            len_done_q <= 1'b0;
            x_q        <= '0;
          end
        end
        S_AAD: begin
          if (accept) begin
            x_q <= x_q ^ blk_masked;
            if (aad_full_q != '0) aad_full_q <= aad_full_q - CNT_W'(1);
            else                  aad_part_q <= 1'b0;
          end
        end
        S_CT: begin
          if (accept) begin
            x_q <= x_q ^ blk_masked;
            if (ct_full_q != '0) ct_full_q <= ct_full_q - CNT_W'(1);
            else                 ct_part_q <= 1'b0;
          end
        end
        S_LEN: begin
          x_q        <= x_q ^ len_blk;
          len_done_q <= 1'b1;
        end
        S_MULT: begin
          z_q    <= z_step;
          v_q    <= v_step;
          mcnt_q <= mcnt_q + MCNT_W'(1);
          // X doubles as the digit shift register; the product replaces it.
          if (mult_last) begin
            x_q <= z_step;
            if (state_d == S_DONE) begin
              ghash_q <= z_step;
              done_q  <= 1'b1;
            end
          end else begin
            x_q <= x_q << DIGIT_BITS;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ghash = ghash_q;
  assign bus.o_done  = done_q;

`ifdef GHASH_STREAM_PARTIAL_OUT_EN
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_x_partial <= '0;
      o_x_valid   <= 1'b0;
    end else begin
      o_x_valid <= mult_last;
      if (mult_last) o_x_partial <= z_step;
    end
  end
`endif

endmodule

// File: tb/tb_ghash_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_ghash_stream_engine
//   Self-checking bench for ghash_stream_engine. A DIGIT_BITS=4 instance
//   runs the directed sequence; four more instances (DIGIT_BITS 1/2/8/16)
//   run the backpressured multi-block message in parallel. Expected digests
//   come from known GCM vectors or from a bit-serial GF(2^128) model and
//   are queued at stimulus time, then popped when o_done fires.
// ---------------------------------------------------------------------------
module tb_ghash_stream_engine;

  localparam int LEN_W      = 64;
  localparam int DIGIT_BITS = 4;
  localparam int M          = 128 / DIGIT_BITS;
  localparam logic [127:0] H_TC    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] TC2_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] TC2_TAG = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] TC2_X1  = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] POLY_R  = {8'hE1, 120'd0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_q [$];
  logic [127:0] stim_blk  [8];
  logic [127:0] model_blk [8];
  int hs_cnt = 0;
  int done_cnt = 0;

  ghash_stream_engine_if #(.LEN_W(LEN_W)) bus ();

`ifdef GHASH_STREAM_PARTIAL_OUT_EN
  logic [127:0] x_partial;
  logic         x_valid;
  logic [127:0] xp [256];
  int           xv_cnt = 0;
`endif

  ghash_stream_engine #(.DIGIT_BITS(DIGIT_BITS), .LEN_W(LEN_W)) u_dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef GHASH_STREAM_PARTIAL_OUT_EN
    ,
    .o_x_partial (x_partial),
    .o_x_valid   (x_valid)
`endif
  );

  always @(posedge clk) begin
    if (bus.i_blk_valid && bus.o_blk_ready) hs_cnt++;
    if (bus.o_done) done_cnt++;
`ifdef GHASH_STREAM_PARTIAL_OUT_EN
    if (x_valid) begin
      xp[xv_cnt % 256] = x_partial;
      xv_cnt++;
    end
`endif
  end

  // ---------------- DIGIT_BITS sweep instances ----------------
  logic             sw_start = 1'b0;
  logic [127:0]     sw_h = '0;
  logic [LEN_W-1:0] sw_aad = '0;
  logic [LEN_W-1:0] sw_ct = '0;
  logic [127:0]     sw_blk [3];
  wire  [31:0]      sw_hs  [4];
  wire  [31:0]      sw_dn  [4];
  wire  [127:0]     sw_got [4];

  for (genvar k = 0; k < 4; k++) begin : g_sw
    localparam int DW = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 16;
    ghash_stream_engine_if #(.LEN_W(LEN_W)) sbus ();
    int hs = 0;
    int dn = 0;
    int idx = 0;
    int gap = 0;
    logic [127:0] got = '0;
`ifdef GHASH_STREAM_PARTIAL_OUT_EN
    logic [127:0] sx_partial;
    logic         sx_valid;
`endif

    assign sbus.i_start    = sw_start;
    assign sbus.i_h        = sw_h;
    assign sbus.i_aad_size = sw_aad;
    assign sbus.i_ct_size  = sw_ct;

    ghash_stream_engine #(.DIGIT_BITS(DW), .LEN_W(LEN_W)) u_sw (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus     (sbus)
`ifdef GHASH_STREAM_PARTIAL_OUT_EN
      ,
      .o_x_partial (sx_partial),
      .o_x_valid   (sx_valid)
`endif
    );

    // Block feeder with random 0-5 cycle valid drops.
    always @(negedge clk) begin
      if (!sbus.o_busy) begin
        idx = 0;
        gap = $urandom_range(0, 5);
        sbus.i_blk_valid = 1'b0;
        sbus.i_blk = '0;
      end else begin
        if (idx < 3 && gap == 0) begin
          sbus.i_blk_valid = 1'b1;
          sbus.i_blk = sw_blk[idx];
        end else begin
          sbus.i_blk_valid = 1'b0;
          if (gap > 0) gap--;
        end
        if (sbus.i_blk_valid && sbus.o_blk_ready) begin
          idx++;
          gap = $urandom_range(0, 5);
        end
      end
    end

    always @(posedge clk) begin
      if (sbus.i_blk_valid && sbus.o_blk_ready) hs++;
      if (sbus.o_done) begin
        dn++;
        got = sbus.o_ghash;
      end
    end

    assign sw_hs[k]  = hs;
    assign sw_dn[k]  = dn;
    assign sw_got[k] = got;
  end

  // ---------------- reference model ----------------
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z = '0;
    logic [127:0] v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z ^= v;
      v = v[0] ? ((v >> 1) ^ POLY_R) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] ghash_model(input logic [127:0] h, input logic [63:0] aad,
                                               input logic [63:0] ct, input int nblk);
    logic [127:0] x = '0;
    for (int i = 0; i < nblk; i++) x = gf_mul(x ^ model_blk[i], h);
    return gf_mul(x ^ {aad, ct}, h);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Runs one hash on the main DUT. restart_at >= 0 pulses a bogus i_start
  // that many cycles in, which must be ignored.
  task automatic run_hash(input string tag, input logic [127:0] h, input logic [63:0] aad,
                          input logic [63:0] ct, input int nblk, input int max_gap,
                          input int restart_at, input logic [127:0] expv);
    int cyc, idx, gap, hs0, dn0;
    bit seen;
    logic [127:0] got, want;
    exp_q.push_back(expv);
    hs0 = hs_cnt;
    dn0 = done_cnt;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_h = h;
    bus.i_aad_size = aad;
    bus.i_ct_size = ct;
    idx = 0;
    gap = $urandom_range(0, max_gap);
    cyc = 0;
    seen = 1'b0;
    got = 'x;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.i_start = (cyc == restart_at);
      if (cyc == restart_at) begin
        bus.i_h = ~h;
        bus.i_aad_size = '0;
        bus.i_ct_size = '0;
      end
      if (bus.o_done) begin
        seen = 1'b1;
        got = bus.o_ghash;
        bus.i_blk_valid = 1'b0;
      end else begin
        if (idx < nblk && gap == 0) begin
          bus.i_blk_valid = 1'b1;
          bus.i_blk = stim_blk[idx];
        end else begin
          bus.i_blk_valid = 1'b0;
          if (gap > 0) gap--;
        end
        if (bus.i_blk_valid && bus.o_blk_ready) begin
          idx++;
          gap = $urandom_range(0, max_gap);
        end
      end
    end
    bus.i_start = 1'b0;
    bus.i_blk_valid = 1'b0;
    check({tag, " done_seen"}, 128'(seen), 128'd1);
    want = exp_q.pop_front();
    check({tag, " ghash"}, got, want);
    check({tag, " handshakes"}, 128'(hs_cnt - hs0), 128'(nblk));
    if (max_gap == 0)
      check({tag, " latency"}, 128'(cyc), 128'((nblk + 1) * (1 + M) + 1));
    @(negedge clk);
    check({tag, " done_pulse_width"}, 128'(bus.o_done), 128'd0);
    check({tag, " busy_after"}, 128'(bus.o_busy), 128'd0);
    check({tag, " done_count"}, 128'(done_cnt - dn0), 128'd1);
  endtask

  initial begin
    logic [127:0] expv, hr, tmp;
    int dn0, t, xb;
    int b0 [4];
    bit all_done;

    bus.i_start = 1'b0;
    bus.i_h = '0;
    bus.i_aad_size = '0;
    bus.i_ct_size = '0;
    bus.i_blk_valid = 1'b0;
    bus.i_blk = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst ready", 128'(bus.o_blk_ready), 128'd0);
    check("rst busy", 128'(bus.o_busy), 128'd0);
    check("rst done", 128'(bus.o_done), 128'd0);
    check("rst ghash", bus.o_ghash, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-length message: only the length block is folded.
    run_hash("zero", H_TC, 64'd0, 64'd0, 0, 0, -1, 128'd0);

    // GCM test case 2.
    stim_blk[0] = TC2_C;
`ifdef GHASH_STREAM_PARTIAL_OUT_EN
    xb = xv_cnt;
`endif
    run_hash("tc2", H_TC, 64'd0, 64'd128, 1, 0, -1, TC2_TAG);
`ifdef GHASH_STREAM_PARTIAL_OUT_EN
    check("tc2 x_partial0", xp[xb % 256], TC2_X1);
`endif

    // 96-bit ciphertext: trailing 32 bits of the block must be ignored.
    tmp = TC2_C;
    stim_blk[0]  = {tmp[127:32], 32'hffffffff};
    model_blk[0] = {tmp[127:32], 32'h00000000};
    expv = ghash_model(H_TC, 64'd0, 64'd96, 1);
    run_hash("mask_ct96", H_TC, 64'd0, 64'd96, 1, 0, -1, expv);

    // Partial last block in both segments: aad=200 (r=72), ct=130 (r=2).
    hr = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      stim_blk[i]  = {$urandom, $urandom, $urandom, $urandom};
      model_blk[i] = stim_blk[i];
    end
    tmp = stim_blk[1];
    model_blk[1] = {tmp[127:56], 56'd0};
    tmp = stim_blk[3];
    model_blk[3] = {tmp[127:126], 126'd0};
    expv = ghash_model(hr, 64'd200, 64'd130, 4);
    run_hash("mask_both", hr, 64'd200, 64'd130, 4, 0, -1, expv);

    // Backpressure: 1 AAD + 2 CT blocks with random valid drops.
    hr = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      stim_blk[i]  = {$urandom, $urandom, $urandom, $urandom};
      model_blk[i] = stim_blk[i];
    end
    expv = ghash_model(hr, 64'd128, 64'd256, 3);
    run_hash("bp_d4", hr, 64'd128, 64'd256, 3, 5, -1, expv);

    // Reset during the second multiply (the length-block multiply).
    dn0 = done_cnt;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_h = H_TC;
    bus.i_aad_size = 64'd0;
    bus.i_ct_size = 64'd128;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_blk_valid = 1'b1;
    bus.i_blk = TC2_C;
    @(negedge clk);
    bus.i_blk_valid = 1'b0;
    repeat (M + 4) @(negedge clk);
    check("rstmid busy_before", 128'(bus.o_busy), 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid ready", 128'(bus.o_blk_ready), 128'd0);
    check("rstmid busy", 128'(bus.o_busy), 128'd0);
    check("rstmid done", 128'(bus.o_done), 128'd0);
    check("rstmid ghash", bus.o_ghash, 128'd0);
    repeat (2 * M + 8) @(negedge clk);
    check("rstmid no_done", 128'(done_cnt - dn0), 128'd0);
    stim_blk[0] = TC2_C;
    run_hash("tc2_after_rst", H_TC, 64'd0, 64'd128, 1, 0, -1, TC2_TAG);

    // i_start while busy must be ignored.
    run_hash("start_busy", H_TC, 64'd0, 64'd128, 1, 0, 10, TC2_TAG);

    // Same backpressured message on DIGIT_BITS = 1, 2, 8, 16.
    sw_h   = {$urandom, $urandom, $urandom, $urandom};
    sw_aad = 64'd128;
    sw_ct  = 64'd256;
    for (int i = 0; i < 3; i++) begin
      sw_blk[i]    = {$urandom, $urandom, $urandom, $urandom};
      model_blk[i] = sw_blk[i];
    end
    expv = ghash_model(sw_h, 64'd128, 64'd256, 3);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(expv);
      b0[k] = int'(sw_dn[k]);
    end
    @(negedge clk);
    sw_start = 1'b1;
    @(negedge clk);
    sw_start = 1'b0;
    t = 0;
    all_done = 1'b0;
    while (!all_done && t < 4000) begin
      @(negedge clk);
      t++;
      all_done = 1'b1;
      for (int k = 0; k < 4; k++)
        if (int'(sw_dn[k]) == b0[k]) all_done = 1'b0;
    end
    check("sweep done_seen", 128'(all_done), 128'd1);
    for (int k = 0; k < 4; k++) begin
      expv = exp_q.pop_front();
      check($sformatf("sweep%0d ghash", k), sw_got[k], expv);
      check($sformatf("sweep%0d handshakes", k), 128'(sw_hs[k]), 128'd3);
      check($sformatf("sweep%0d done_count", k), 128'(int'(sw_dn[k]) - b0[k]), 128'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ghash_stream_engine.md
Name: ghash_stream_engine

Overview:
- Parametrised, streaming GHASH engine for the GCM datapath. It accumulates X_i = (X_{i-1} xor B_i) * H over GF(2^128) across an arbitrary number of AAD and ciphertext blocks, then folds in the length block.
- It replaces the fixed single-AAD / single-plaintext-block hashing path of gcm_aes. Multi-block messages and partial final blocks become possible.
- Sits between the CTR-mode encryptor (ciphertext blocks) and the tag XOR stage.

Parameters:
- DIGIT_BITS, 4, multiplier bits consumed per cycle. Legal values are 1, 2, 4, 8, 16. One multiply takes 128/DIGIT_BITS cycles.
- LEN_W, 64, width of the AAD and ciphertext bit-length inputs.

Ports:
- clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  one-cycle pulse; begin new hash. Samples i_h, i_aad_size, i_ct_size.
- i_h  in  128  hash subkey H = AES_K(0^128). Bit 0 = MSB, GCM bit order.
- i_aad_size  in  LEN_W  AAD length in bits.
- i_ct_size  in  LEN_W  ciphertext length in bits.
- i_blk_valid  in  1  input block valid.
- o_blk_ready  out  1  engine accepts a block this cycle.
- i_blk  in  128  AAD blocks first, then ciphertext blocks, MSB-first.
- o_busy  out  1  hash in progress.
- o_ghash  out  128  final GHASH value, held until next i_start.
- o_done  out  1  one-cycle pulse when o_ghash is valid.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - State goes to IDLE.
  - o_blk_ready=0, o_busy=0, o_done=0, o_ghash=0.
  - Internal X, H, counters are cleared.
  - Reset mid-operation abandons the hash; no o_done is produced.
- i_start in IDLE or DONE:
  - Latch H and both lengths; clear X=0.
  - Derive n_aad = ceil(aad_size/128) and n_ct = ceil(ct_size/128).
  - Go to AAD if n_aad>0, else CT if n_ct>0, else LEN.
- i_start while busy is ignored.
- States: IDLE, AAD, CT, LEN, MULT, DONE.
- AAD and CT states:
  - o_blk_ready=1 only in these states.
  - A block is accepted when i_blk_valid & o_blk_ready.
  - On accept: X <= X xor mask(i_blk), then go to MULT. Decrement the relevant block counter.
  - mask: on the final block of a segment with size mod 128 = r != 0, bits r..127 are forced to 0. Other blocks are unmasked.
- LEN state:
  - No handshake.
  - X <= X xor {aad_size zero-extended to 64 bits, ct_size zero-extended to 64 bits}, then go to MULT.
- MULT state:
  - Shift-and-add GF(2^128) multiply X*H using polynomial R = 0xE1 || 0^120 (right-shift convention).
  - Processes DIGIT_BITS bits of X per cycle, MSB first, in exactly 128/DIGIT_BITS cycles.
  - On completion, next state is chosen by priority:
    1. AAD if AAD blocks remain.
    2. CT if ciphertext blocks remain.
    3. LEN if the length block is not yet folded.
    4. Otherwise DONE.
- DONE state:
  - o_ghash <= X.
  - o_done=1 for one cycle on entry.
  - o_busy=0. Wait for i_start.
- o_busy is 1 in AAD, CT, LEN, MULT.
- Latency:
  - Per block: 1 accept cycle + 128/DIGIT_BITS multiply cycles.
  - Total from i_start with no input stalls: (n_aad + n_ct + 1) * (1 + 128/DIGIT_BITS) + 1 cycles.
- Backpressure: i_blk_valid low while ready simply stalls the engine. No timeout.
- i_blk_valid outside AAD/CT is ignored.
- Length arithmetic:
  - Block counters are LEN_W-7 bits wide.
  - The ceil computation must not overflow at size = 2^LEN_W - 1.

Optional Feature:
- Macro GHASH_STREAM_PARTIAL_OUT_EN.
- When defined, two extra ports are added:
  - o_x_partial  out  128: X after each completed multiply.
  - o_x_valid  out  1: one-cycle pulse at each MULT exit.
- These allow per-block comparison against a software model.
- When undefined, the ports and their logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Zero message: i_h=66e94bd4ef8a2c3b884cfa59ca342b2e, sizes 0/0, i_start.
  - No block handshake occurs.
  - o_done after 1+128/DIGIT_BITS+1 cycles, with o_ghash=0.
- GCM test case 2: same H, aad_size=0, ct_size=128, block 0388dace60b6a392f328c2b971b2fe78.
  - o_ghash = f38cbb1ad69223dcc3457ae5b6b0f885.
  - With GHASH_STREAM_PARTIAL_OUT_EN, the first o_x_partial = 5e2ec746917062882c85b0685353deb7.
- Partial-block masking: ct_size=96; drive the TC2 block with the low 32 bits set to ffffffff.
  - Result equals the run with those bits set to 0.
  - The length block carries 0x60.
- Backpressure and ordering: aad_size=128, ct_size=256; drop i_blk_valid randomly for 0-5 cycles.
  - Exactly 3 handshakes occur.
  - Result matches the software model.
  - Repeat for every legal DIGIT_BITS.
- Reset mid-MULT: assert i_rst_n=0 for one cycle during the second multiply.
  - All outputs go to 0 next cycle, with no o_done.
  - A following i_start for TC2 gives the correct result.
- i_start during busy is ignored: the current hash completes with the correct value and only one o_done.
